// File: rtl/umi_fir_filter_pkg.sv
// Shared constants for the UMI FIR register bank: register map, CTRL/STATUS bit positions
// and the commit state encoding.
package umi_fir_filter_pkg;

  localparam int unsigned CTRL_REG_ADDR   = 0;
  localparam int unsigned STATUS_REG_ADDR = 1;
  localparam int unsigned COEFF_BASE_ADDR = 2;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_COMMIT_BIT  = 1;
  localparam int CTRL_CLR_ERR_BIT = 2;
  localparam int CTRL_LOCK_BIT    = 3;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_ERR_BIT     = 1;
  localparam int STATUS_CNT_LSB     = 8;
  localparam int STATUS_CNT_WIDTH   = 8;

  typedef enum logic {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/umi_fir_filter_regbank_if.sv
// Register-access channel between the UMI request adapter (master) and the regbank (slave).
// Request is valid/ready; read response is valid/ready with data held until consumed.
interface umi_fir_filter_regbank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/umi_fir_filter_coeff_bank.sv
// Shadow/active coefficient storage: host writes land in shadow on the accept edge,
// commit copies the whole shadow bank to active in one cycle; no backpressure.
module umi_fir_filter_coeff_bank #(
  parameter int NUM_COEFF   = 8,
  parameter int COEFF_WIDTH = 16,
  parameter int IDX_W       = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [COEFF_WIDTH-1:0]           wr_data,
  input  logic                             commit,
  output logic [NUM_COEFF*COEFF_WIDTH-1:0] shadow,
  output logic [NUM_COEFF*COEFF_WIDTH-1:0] active
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en) begin
        shadow[wr_idx*COEFF_WIDTH +: COEFF_WIDTH] <= wr_data;
      end
      // Writes are refused while a commit is pending, so wr_en and commit never overlap.
      if (commit) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: rtl/umi_fir_filter_regbank.sv
// FIR control/status/coefficient regbank; reads respond 1 cycle after accept, one read outstanding,
// req_ready drops while a response is stalled. Optional write lock under UMI_FIR_REGBANK_LOCK_EN.
module umi_fir_filter_regbank
  import umi_fir_filter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_COEFF   = 8,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  umi_fir_filter_regbank_if.slave          bus,
  input  logic                             filter_idle,
  output logic                             enable,
  output logic [NUM_COEFF*COEFF_WIDTH-1:0] coeff,
  output logic                             commit_done
);

  localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  commit_state_t               state;
  logic                        err;
  logic [STATUS_CNT_WIDTH-1:0] commit_cnt;
  logic                        rsp_valid_q;
  logic [DATA_WIDTH-1:0]       rsp_data_q;
  logic                        locked;

  logic                          pending;
  logic                          acc, rd_acc, wr_acc;
  logic                          is_ctrl, is_status, is_coeff, is_unmapped;
  logic [31:0]                   addr_ext, coeff_off;
  logic [IDX_W-1:0]              coeff_idx;
  logic                          ctrl_wr, coeff_wr, clr_err, err_set, commit_req, commit_fire;
  logic [NUM_COEFF*COEFF_WIDTH-1:0] shadow;
  logic [COEFF_WIDTH-1:0]        shadow_word;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          unused_bits;

  assign pending  = (state == COMMIT_PENDING);
  assign bus.req_ready = !(rsp_valid_q && !bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign acc    = bus.req_valid && bus.req_ready;
  assign rd_acc = acc && !bus.req_write;
  assign wr_acc = acc && bus.req_write;

  assign addr_ext    = 32'(bus.req_addr);
  assign coeff_off   = addr_ext - COEFF_BASE_ADDR;
  assign coeff_idx   = coeff_off[IDX_W-1:0];
  assign is_ctrl     = (addr_ext == CTRL_REG_ADDR);
  assign is_status   = (addr_ext == STATUS_REG_ADDR);
  assign is_coeff    = (addr_ext >= COEFF_BASE_ADDR) && (addr_ext < COEFF_BASE_ADDR + NUM_COEFF);
  assign is_unmapped = !is_ctrl && !is_status && !is_coeff;
  assign unused_bits = ^{bus.req_wdata, coeff_off};

  // clr_err is honoured even when locked; every other write under lock is refused and flagged.
  assign clr_err    = wr_acc && is_ctrl && bus.req_wdata[CTRL_CLR_ERR_BIT];
  assign ctrl_wr    = wr_acc && is_ctrl && !locked;
  assign coeff_wr   = wr_acc && is_coeff && !locked && !pending;
  assign commit_req = ctrl_wr && bus.req_wdata[CTRL_COMMIT_BIT];
  assign err_set    = (acc && is_unmapped)
                   || (wr_acc && is_status)
                   || (wr_acc && is_coeff && pending)
                   || (wr_acc && locked && !clr_err);
  assign commit_fire = pending && filter_idle;

`ifdef UMI_FIR_REGBANK_LOCK_EN
  logic lock;
  assign locked = lock;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock <= 1'b0;
    end else if (ctrl_wr && bus.req_wdata[CTRL_LOCK_BIT]) begin
      lock <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  umi_fir_filter_coeff_bank #(
    .NUM_COEFF   (NUM_COEFF),
    .COEFF_WIDTH (COEFF_WIDTH),
    .IDX_W       (IDX_W)
  ) u_coeff_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (coeff_wr),
    .wr_idx  (coeff_idx),
    .wr_data (bus.req_wdata[COEFF_WIDTH-1:0]),
    .commit  (commit_fire),
    .shadow  (shadow),
    .active  (coeff)
  );

  assign shadow_word = shadow[coeff_idx*COEFF_WIDTH +: COEFF_WIDTH];

  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      rd_data[CTRL_ENABLE_BIT] = enable;
`ifdef UMI_FIR_REGBANK_LOCK_EN
      rd_data[CTRL_LOCK_BIT] = lock;
`endif
    end else if (is_status) begin
      rd_data[STATUS_PENDING_BIT] = pending;
      rd_data[STATUS_ERR_BIT]     = err;
      rd_data[STATUS_CNT_LSB +: STATUS_CNT_WIDTH] = commit_cnt;
    end else if (is_coeff) begin
      rd_data[COEFF_WIDTH-1:0] = shadow_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_acc) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= bus.req_wdata[CTRL_ENABLE_BIT];
      end
      if (err_set) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COMMIT_IDLE;
      commit_done <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        COMMIT_IDLE: begin
          if (commit_req) begin
            state <= COMMIT_PENDING;
          end
        end
        COMMIT_PENDING: begin
          if (filter_idle) begin
            state       <= COMMIT_IDLE;
            commit_done <= 1'b1;
            commit_cnt  <= commit_cnt + 1'b1;
          end
        end
        default: state <= COMMIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_fir_filter_regbank.sv
// Directed bench for umi_fir_filter_regbank with a per-cycle reference model and literal spot checks.
module tb_umi_fir_filter_regbank;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic filter_idle = 1'b0;
  logic enable;
  logic [NC*CW-1:0] coeff;
  logic commit_done;

  int checks = 0;
  int errors = 0;

  umi_fir_filter_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  umi_fir_filter_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COEFF(NC), .COEFF_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .filter_idle (filter_idle),
    .enable      (enable),
    .coeff       (coeff),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: register contents as plain arrays/flags, advanced once per clock edge.
  logic [15:0] sh_m [NC];
  logic [15:0] ac_m [NC];
  bit          en_m, err_m, pend_m, lock_m, done_m, rspv_m;
  logic [7:0]  cnt_m;
  logic [31:0] rdat_m;

  always @(posedge clk or posedge reset) begin
    bit acc, es, clr, was_pend;
    int a;
    logic [31:0] wd;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
      en_m = 0; err_m = 0; pend_m = 0; lock_m = 0; done_m = 0; rspv_m = 0;
      cnt_m = 0; rdat_m = 0;
    end else begin
      was_pend = pend_m;
      acc = bus.req_valid && !(rspv_m && !bus.rsp_ready);
      a = int'(bus.req_addr);
      wd = bus.req_wdata;
      es = 0; clr = 0; done_m = 0;
      if (rspv_m && bus.rsp_ready) rspv_m = 0;
      if (acc && !bus.req_write) begin
        rspv_m = 1;
        if (a == 0)                rdat_m = {28'd0, lock_m, 2'b00, en_m};
        else if (a == 1)           rdat_m = {16'd0, cnt_m, 6'd0, err_m, pend_m};
        else if (a >= 2 && a < 10) rdat_m = {16'd0, sh_m[a-2]};
        else begin rdat_m = 0; es = 1; end
      end else if (acc) begin
        if (lock_m && !(a == 0 && wd[2])) es = 1;
        else if (a == 0) begin
          clr = wd[2];
          if (!lock_m) begin
            en_m = wd[0];
            if (wd[1] && !was_pend) pend_m = 1;
`ifdef UMI_FIR_REGBANK_LOCK_EN
            if (wd[3]) lock_m = 1;
`endif
          end
        end
        else if (a == 1) es = 1;
        else if (a < 10) begin
          if (was_pend) es = 1;
          else sh_m[a-2] = wd[15:0];
        end
        else es = 1;
      end
      if (was_pend && filter_idle) begin
        for (int i = 0; i < NC; i++) ac_m[i] = sh_m[i];
        done_m = 1; cnt_m = cnt_m + 8'd1; pend_m = 0;
      end
      if (es) err_m = 1;
      else if (clr) err_m = 0;
    end
  end

  always @(negedge clk) begin
    logic [NC*CW-1:0] exp_coeff;
    if (!reset) begin
      for (int i = 0; i < NC; i++) exp_coeff[i*CW +: CW] = ac_m[i];
      chk("cyc_coeff", 128'(coeff), 128'(exp_coeff));
      chk("cyc_enable", 128'(enable), 128'(en_m));
      chk("cyc_commit_done", 128'(commit_done), 128'(done_m));
      chk("cyc_rsp_valid", 128'(bus.rsp_valid), 128'(rspv_m));
      chk("cyc_rsp_data", 128'(bus.rsp_data), 128'(rdat_m));
      chk("cyc_req_ready", 128'(bus.req_ready), 128'(!(rspv_m && !bus.rsp_ready)));
    end
  end

  task automatic wait_accept(string nm);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) chk({nm, "_accept_timeout"}, 128'(0), 128'(1));
  endtask

  task automatic wr(int a, logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = AW'(a); bus.req_wdata = d;
    wait_accept("wr");
  endtask

  task automatic rd(string nm, int a, logic [31:0] exp);
    bit got = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = AW'(a);
    wait_accept(nm);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1; chk(nm, 128'(bus.rsp_data), 128'(exp)); end
      @(posedge clk); #1;
    end
    if (!got) chk({nm, "_rsp_timeout"}, 128'(0), 128'(1));
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int pulses;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1;
    cycles(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("rst_coeff", 128'(coeff), 128'(0));
    chk("rst_enable", 128'(enable), 128'(0));
    @(posedge clk); #1;
    rd("rst_ctrl", 0, 32'h0);
    rd("rst_status", 1, 32'h0);
    rd("rst_coeff0", 2, 32'h0);

    // Commit held off until filter_idle
    for (int i = 0; i < NC; i++) wr(2 + i, 32'(i + 1));
    wr(0, 32'h2);
    cycles(10);
    chk("commit_held_coeff", 128'(coeff), 128'(0));
    rd("status_pending", 1, 32'h0001);
    filter_idle = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); pulses += int'(commit_done);
    end
    @(posedge clk); #1;
    chk("commit_done_pulses", 128'(pulses), 128'(1));
    chk("commit_taps", 128'(coeff),
        {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    rd("status_after_commit", 1, 32'h0100);

    // Stalled response: data held, ready low, second read waits
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = AW'(4);
    cycles(1);
    bus.req_addr = AW'(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_data", 128'(bus.rsp_data), 128'(3));
      chk("stall_req_ready", 128'(bus.req_ready), 128'(0));
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("release_req_ready", 128'(bus.req_ready), 128'(1));
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    chk("second_read_data", 128'(bus.rsp_data), 128'(4));
    @(posedge clk); #1;

    // Back-to-back reads at full rate
    bus.req_valid = 1; bus.req_addr = AW'(2);
    cycles(1);
    bus.req_addr = AW'(3);
    @(negedge clk); chk("b2b_0", 128'(bus.rsp_data), 128'(1));
    @(posedge clk); #1;
    bus.req_addr = AW'(4);
    @(negedge clk); chk("b2b_1", 128'(bus.rsp_data), 128'(2));
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk); chk("b2b_2", 128'({bus.rsp_valid, bus.rsp_data}), {95'd0, 1'b1, 32'd3});
    @(posedge clk); #1;

    // Error sources and clr_err
    wr(15, 32'h0);
    rd("err_unmapped_wr", 1, 32'h0102);
    wr(0, 32'h4);
    rd("err_cleared", 1, 32'h0100);
    wr(1, 32'hFFFF);
    rd("err_status_wr", 1, 32'h0102);
    wr(0, 32'h4);
    rd("unmapped_read", 12, 32'h0);
    rd("err_unmapped_rd", 1, 32'h0102);
    wr(0, 32'h4);
    filter_idle = 1'b0;
    wr(0, 32'h2);
    wr(2, 32'h55);
    rd("err_coeff_pending", 1, 32'h0103);
    rd("shadow_unchanged", 2, 32'h1);
    filter_idle = 1'b1;
    cycles(3);
    wr(0, 32'h4);
    rd("status_second_commit", 1, 32'h0200);

    // Enable bit; bit 3 has no storage in the default build
    wr(0, 32'h1);
    rd("ctrl_enable", 0, 32'h1);
    chk("enable_out", 128'(enable), 128'(1));
`ifndef UMI_FIR_REGBANK_LOCK_EN
    wr(0, 32'h8);
    rd("ctrl_bit3_ignored", 0, 32'h0);
`endif

    // commit_cnt wraps: two commits done, 254 more reach 256
    for (int i = 0; i < 254; i++) begin
      wr(0, 32'h2);
      cycles(2);
    end
    rd("cnt_wrap", 1, 32'h0000);

    // Reset while a commit is pending
    filter_idle = 1'b0;
    wr(3, 32'h77);
    wr(0, 32'h2);
    cycles(1);
    reset = 1'b1;
    filter_idle = 1'b1;
    cycles(1);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); pulses += int'(commit_done);
    end
    @(posedge clk); #1;
    chk("rst_pending_no_pulse", 128'(pulses), 128'(0));
    chk("rst_pending_coeff", 128'(coeff), 128'(0));
    rd("rst_pending_shadow", 3, 32'h0);
    rd("rst_pending_status", 1, 32'h0);

`ifdef UMI_FIR_REGBANK_LOCK_EN
    wr(0, 32'h9);
    rd("lock_ctrl", 0, 32'h9);
    wr(2, 32'h99);
    rd("lock_err", 1, 32'h0002);
    rd("lock_dropped", 2, 32'h0);
    wr(0, 32'h4);
    rd("lock_clr_err", 1, 32'h0);
`endif

    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
